// File: rtl/tile_reader.sv
`default_nettype none
// ============================================================================
// Module      : tile_reader
// Description : Pipelined Avalon-MM read master that loads a 32x16 tile of
//               32-bit pixels from memory into tile RAM. Optional clear mode
//               is built when TILE_READER_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_reader #(
    parameter int MAX_PENDING = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] addr_in,
    input  logic [15:0] stride_in,
`ifdef TILE_READER_CLEAR_EN
    input  logic        clear,
    input  logic [31:0] clear_value,
`endif
    output logic        busy,
    output logic        done,
    output logic [8:0]  ram_addr_out,
    output logic [31:0] ram_data_out,
    output logic        ram_wren,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic        master_wait_request,
    input  logic [31:0] master_read_data,
    input  logic        master_read_data_valid
);

    localparam int         TILE_WORDS  = 512;
    localparam logic [9:0] ISSUE_LIMIT = 10'(TILE_WORDS);
    localparam logic [5:0] PEND_LIMIT  = 6'(MAX_PENDING);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1
`ifdef TILE_READER_CLEAR_EN
        ,
        S_CLEAR = 2'd2
`endif
    } state_t;

    state_t      state, state_next;
    logic [31:0] addr_q, addr_next;
    logic [15:0] stride_q, stride_next;
    logic [9:0]  issue_cnt, issue_next;
    logic [8:0]  recv_cnt, recv_next;
    logic [5:0]  in_flight, in_flight_next;
    logic        read_q, read_next;
`ifdef TILE_READER_CLEAR_EN
    logic [31:0] fill_q, fill_next;
`endif

    logic accept;
    logic resp;
    logic last_word;

    assign accept    = read_q && !master_wait_request;
    assign resp      = (state == S_READ) && master_read_data_valid;
    assign last_word = (recv_cnt == 9'd511);

    assign busy           = (state != S_IDLE);
    assign master_read    = read_q;
    assign master_address = addr_q;
    assign done           = ram_wren && last_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            stride_q  <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            in_flight <= '0;
            read_q    <= 1'b0;
`ifdef TILE_READER_CLEAR_EN
            fill_q    <= '0;
`endif
        end else begin
            state     <= state_next;
            addr_q    <= addr_next;
            stride_q  <= stride_next;
            issue_cnt <= issue_next;
            recv_cnt  <= recv_next;
            in_flight <= in_flight_next;
            read_q    <= read_next;
`ifdef TILE_READER_CLEAR_EN
            fill_q    <= fill_next;
`endif
        end
    end

    always_comb begin
        state_next     = state;
        addr_next      = addr_q;
        stride_next    = stride_q;
        issue_next     = issue_cnt;
        recv_next      = recv_cnt;
        in_flight_next = in_flight;
        read_next      = read_q;
`ifdef TILE_READER_CLEAR_EN
        fill_next      = fill_q;
`endif
        ram_wren       = 1'b0;
        ram_addr_out   = '0;
        ram_data_out   = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_next      = addr_in;
                    stride_next    = stride_in;
                    issue_next     = '0;
                    recv_next      = '0;
                    in_flight_next = '0;
`ifdef TILE_READER_CLEAR_EN
                    if (clear) begin
                        state_next = S_CLEAR;
                        fill_next  = clear_value;
                    end else begin
                        state_next = S_READ;
                        read_next  = 1'b1;
                    end
`else
                    state_next = S_READ;
                    read_next  = 1'b1;
`endif
                end
            end

            S_READ: begin
                if (accept) begin
                    issue_next = issue_cnt + 10'd1;
                    // End of a 16-word row: jump to the next row start.
                    if (issue_cnt[3:0] == 4'hF)
                        addr_next = addr_q + {16'd0, stride_q} - 32'd60;
                    else
                        addr_next = addr_q + 32'd4;
                end
                in_flight_next = in_flight + {5'd0, accept} - {5'd0, resp};

                if (resp) begin
                    ram_wren     = 1'b1;
                    ram_addr_out = recv_cnt;
                    ram_data_out = master_read_data;
                    recv_next    = recv_cnt + 9'd1;
                end

                // A stalled request must hold; otherwise raise only with credit.
                if (read_q && master_wait_request)
                    read_next = 1'b1;
                else
                    read_next = (issue_next < ISSUE_LIMIT) && (in_flight_next < PEND_LIMIT);

                if (resp && last_word) begin
                    state_next = S_IDLE;
                    read_next  = 1'b0;
                end
            end

`ifdef TILE_READER_CLEAR_EN
            S_CLEAR: begin
                ram_wren     = 1'b1;
                ram_addr_out = recv_cnt;
                ram_data_out = fill_q;
                recv_next    = recv_cnt + 9'd1;
                if (last_word)
                    state_next = S_IDLE;
            end
`endif

            default: begin
                state_next = S_IDLE;
                read_next  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
